// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the hh:mm:ss timer set controller.
// Imported by the debouncer and the controller top.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_MIN  = 2'b01;
    localparam logic [1:0] FIELD_HOUR = 2'b10;

    localparam logic [5:0] MASK_NONE = 6'b000000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_HOUR = 6'b110000;

    // A divider of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/timer_set_controller_key_debounce.sv
// Button conditioner: two-flop synchroniser, stable-level debounce
// and a one-cycle pulse when the debounced level rises.
module key_debounce
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          settled;

    assign differ  = sync2_q != level_q;
    assign settled = differ && (32'(cnt_q) == DEBOUNCE_CYC - 1);

    // Any cycle that agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d = '0;
        if (differ && !settled) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= settled && sync2_q;
            if (settled) begin
                level_q <= sync2_q;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/timer_set_controller.sv
// Run/set mode sequencer for the hh:mm:ss timer: key handling, 1 Hz
// tick, edit commands, set-mode timeout and digit blink mask.
module timer_set_controller
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned DEBOUNCE_CYC = 20,
    parameter int unsigned TIMEOUT_CYC  = 1000000000,
    parameter int unsigned BLINK_DIV    = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_state,
    input  logic       set_key,
    input  logic       increase_key,
    output logic       run_en,
    output logic       sec_tick,
    output logic       set_mode,
    output logic [1:0] set_field,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       clr_sec,
    output logic [5:0] blink_mask
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam int IW = cnt_width(TIMEOUT_CYC);
    localparam int BW = cnt_width(BLINK_DIV);

    logic set_press;
    logic inc_press;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_set_key (
        .clk    (clk),
        .rst_n  (reset),
        .key_i  (set_key),
        .press_o(set_press)
    );

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_inc_key (
        .clk    (clk),
        .rst_n  (reset),
        .key_i  (increase_key),
        .press_o(inc_press)
    );

    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;
    logic [BW-1:0] blink_q;
    logic [BW-1:0] blink_d;
    logic          phase_q;
    logic          phase_d;

    logic          run_en_q;
    logic          sec_tick_q;
    logic          set_mode_q;
    logic [1:0]    set_field_q;
    logic [1:0]    set_field_d;
    logic          inc_min_q;
    logic          inc_min_d;
    logic          inc_hour_q;
    logic          inc_hour_d;
    logic          clr_sec_q;
    logic          clr_sec_d;
    logic [5:0]    mask_q;
    logic [5:0]    mask_d;

    logic          tick_end;
    logic          idle_end;
    logic          blink_end;
    logic          in_set_d;
    logic          enter_set;
    logic          edit;
    logic          run_stay;

    assign tick_end  = 32'(tick_q) == TICK_DIV - 1;
    assign idle_end  = 32'(idle_q) == TIMEOUT_CYC - 1;
    assign blink_end = 32'(blink_q) == BLINK_DIV - 1;

    // Set press beats a same-cycle increase press.
    always_comb begin
        state_d    = state_q;
        inc_min_d  = 1'b0;
        inc_hour_d = 1'b0;
        clr_sec_d  = 1'b0;
        if (!power_state) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (set_press) begin
                        state_d   = ST_SET_MIN;
                        clr_sec_d = 1'b1;
                    end
                end
                ST_SET_MIN: begin
                    if (set_press) begin
                        state_d = ST_SET_HOUR;
                    end else if (inc_press) begin
                        inc_min_d = 1'b1;
                    end else if (idle_end) begin
                        state_d = ST_RUN;
                    end
                end
                ST_SET_HOUR: begin
                    if (set_press) begin
                        state_d = ST_RUN;
                    end else if (inc_press) begin
                        inc_hour_d = 1'b1;
                    end else if (idle_end) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    assign in_set_d  = (state_d == ST_SET_MIN) || (state_d == ST_SET_HOUR);
    assign enter_set = in_set_d && (state_d != state_q);
    assign edit      = enter_set || inc_min_d || inc_hour_d;
    assign run_stay  = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_comb begin
        tick_d = '0;
        if (run_stay && !tick_end) begin
            tick_d = tick_q + TW'(1);
        end

        idle_d = '0;
        if (in_set_d && !edit) begin
            idle_d = idle_q + IW'(1);
        end

        // Each edit restarts the visible half-period.
        blink_d = '0;
        phase_d = 1'b0;
        if (in_set_d && !edit) begin
            phase_d = phase_q;
            if (blink_end) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end

        mask_d = MASK_NONE;
        if (phase_d) begin
            mask_d = (state_d == ST_SET_HOUR) ? MASK_HOUR : MASK_MIN;
        end

        unique case (state_d)
            ST_SET_MIN:  set_field_d = FIELD_MIN;
            ST_SET_HOUR: set_field_d = FIELD_HOUR;
            default:     set_field_d = FIELD_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_OFF;
            tick_q      <= '0;
            idle_q      <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            run_en_q    <= 1'b0;
            sec_tick_q  <= 1'b0;
            set_mode_q  <= 1'b0;
            set_field_q <= FIELD_NONE;
            inc_min_q   <= 1'b0;
            inc_hour_q  <= 1'b0;
            clr_sec_q   <= 1'b0;
            mask_q      <= MASK_NONE;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            run_en_q    <= state_d == ST_RUN;
            sec_tick_q  <= run_stay && tick_end;
            set_mode_q  <= in_set_d;
            set_field_q <= set_field_d;
            inc_min_q   <= inc_min_d;
            inc_hour_q  <= inc_hour_d;
            clr_sec_q   <= clr_sec_d;
            mask_q      <= mask_d;
        end
    end

    assign run_en     = run_en_q;
    assign sec_tick   = sec_tick_q;
    assign set_mode   = set_mode_q;
    assign set_field  = set_field_q;
    assign inc_min    = inc_min_q;
    assign inc_hour   = inc_hour_q;
    assign clr_sec    = clr_sec_q;
    assign blink_mask = mask_q;

endmodule

// File: tb/tb_timer_set_controller.sv
// Bench for timer_set_controller: timing-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_timer_set_controller;

    localparam int TD  = 10;
    localparam int DEB = 4;
    localparam int TO  = 40;
    localparam int BD  = 5;

    localparam bit [5:0] M_MIN  = 6'b001100;
    localparam bit [5:0] M_HOUR = 6'b110000;

    logic       clk;
    logic       reset;
    logic       power_state;
    logic       set_key;
    logic       increase_key;
    logic       run_en;
    logic       sec_tick;
    logic       set_mode;
    logic [1:0] set_field;
    logic       inc_min;
    logic       inc_hour;
    logic       clr_sec;
    logic [5:0] blink_mask;

    timer_set_controller #(
        .TICK_DIV    (TD),
        .DEBOUNCE_CYC(DEB),
        .TIMEOUT_CYC (TO),
        .BLINK_DIV   (BD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .power_state (power_state),
        .set_key     (set_key),
        .increase_key(increase_key),
        .run_en      (run_en),
        .sec_tick    (sec_tick),
        .set_mode    (set_mode),
        .set_field   (set_field),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .clr_sec     (clr_sec),
        .blink_mask  (blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: 0 off, 1 run, 2 set minute, 3 set hour.
    int       m_st      = 0;
    int       m_age     = 0;
    int       m_run_age = 0;
    int       prev_st   = 0;
    bit       pend_set  = 0;
    bit       pend_inc  = 0;
    bit       lvl_set   = 0;
    bit       lvl_inc   = 0;
    bit [7:0] h_set     = '0;
    bit [7:0] h_inc     = '0;
    bit       e_tick    = 0;
    bit       e_imin    = 0;
    bit       e_ihour   = 0;
    bit       e_clr     = 0;
    bit [5:0] e_mask    = '0;
    bit       f_set;
    bit       f_inc;

    // h[0] is the newest raw sample; the debouncer compares h[2] onward.
    function automatic bit flips(input bit [7:0] h, input bit lvl);
        for (int k = 2; k < DEB + 2; k++) begin
            if (h[k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_age = 0; m_run_age = 0;
            pend_set = 0; pend_inc = 0;
            lvl_set = 0; lvl_inc = 0;
            h_set = '0; h_inc = '0;
            e_tick = 0; e_imin = 0; e_ihour = 0; e_clr = 0;
            e_mask = '0;
        end else begin
            prev_st = m_st;
            e_imin = 0; e_ihour = 0; e_clr = 0;
            if (!power_state) begin
                m_st = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (pend_set) begin
                    m_st = 2; m_age = 0; e_clr = 1;
                end
            end else begin
                if (pend_set) begin
                    m_st = (m_st == 2) ? 3 : 1;
                    m_age = 0;
                end else if (pend_inc) begin
                    if (m_st == 2) e_imin = 1;
                    else e_ihour = 1;
                    m_age = 0;
                end else if (m_age == TO - 1) begin
                    m_st = 1;
                end else begin
                    m_age++;
                end
            end
            m_run_age = (m_st == 1 && prev_st == 1) ? m_run_age + 1 : 0;
            e_tick = (m_st == 1) && (prev_st == 1) && (m_run_age % TD == 0);
            e_mask = '0;
            if (m_st >= 2 && ((m_age / BD) % 2) == 1)
                e_mask = (m_st == 2) ? M_MIN : M_HOUR;
            h_set = {h_set[6:0], set_key};
            h_inc = {h_inc[6:0], increase_key};
            f_set = flips(h_set, lvl_set);
            f_inc = flips(h_inc, lvl_inc);
            if (f_set) lvl_set = ~lvl_set;
            if (f_inc) lvl_inc = ~lvl_inc;
            pend_set = f_set && lvl_set;
            pend_inc = f_inc && lvl_inc;
        end
    end

    int c_imin  = 0;
    int c_ihour = 0;

    always @(negedge clk) begin
        check("run_en", 32'(run_en), 32'(m_st == 1));
        check("sec_tick", 32'(sec_tick), 32'(e_tick));
        check("set_mode", 32'(set_mode), 32'(m_st >= 2));
        check("set_field", 32'(set_field),
              (m_st == 2) ? 32'd1 : (m_st == 3) ? 32'd2 : 32'd0);
        check("inc_min", 32'(inc_min), 32'(e_imin));
        check("inc_hour", 32'(inc_hour), 32'(e_ihour));
        check("clr_sec", 32'(clr_sec), 32'(e_clr));
        check("blink_mask", 32'(blink_mask), 32'(e_mask));
        if (inc_min === 1'b1) c_imin++;
        if (inc_hour === 1'b1) c_ihour++;
    end

    task automatic press_key(input bit is_set);
        @(negedge clk);
        if (is_set) set_key = 1'b1;
        else increase_key = 1'b1;
        repeat (8) @(negedge clk);
        set_key = 1'b0;
        increase_key = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int  b_min;
    int  b_hour;
    bit  saw_mode;

    initial begin
        reset = 1'b0;
        power_state = 1'b1;
        set_key = 1'b0;
        increase_key = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_run_en", 32'(run_en), 0);
        check("rst_sec_tick", 32'(sec_tick), 0);
        check("rst_set_mode", 32'(set_mode), 0);
        check("rst_set_field", 32'(set_field), 0);
        check("rst_clr_sec", 32'(clr_sec), 0);
        check("rst_mask", 32'(blink_mask), 0);

        // Reset release: RUN one clock later, first tick 10 cycles on.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("run_after_reset", 32'(run_en), 1);
        repeat (9) @(negedge clk);
        check("tick_not_yet", 32'(sec_tick), 0);
        @(negedge clk);
        check("first_tick", 32'(sec_tick), 1);
        @(negedge clk);
        check("tick_one_cycle", 32'(sec_tick), 0);

        // Clean set press: mode change 7 clocks after the raw edge.
        @(negedge clk);
        set_key = 1'b1;
        repeat (6) @(negedge clk);
        check("set_before_latency", 32'(set_mode), 0);
        @(negedge clk);
        check("set_mode_enter", 32'(set_mode), 1);
        check("set_field_min", 32'(set_field), 1);
        check("clr_sec_pulse", 32'(clr_sec), 1);
        check("run_en_off_in_set", 32'(run_en), 0);
        @(negedge clk);
        check("clr_sec_single", 32'(clr_sec), 0);
        repeat (6) @(negedge clk);
        set_key = 1'b0;
        repeat (8) @(negedge clk);

        // Three minute increments, then hour field with two.
        b_min = c_imin;
        b_hour = c_ihour;
        repeat (3) press_key(1'b0);
        check("inc_min_count", c_imin - b_min, 3);
        check("no_inc_hour", c_ihour - b_hour, 0);
        press_key(1'b1);
        check("set_field_hour", 32'(set_field), 2);
        b_min = c_imin;
        b_hour = c_ihour;
        repeat (2) press_key(1'b0);
        check("inc_hour_count", c_ihour - b_hour, 2);
        check("no_inc_min", c_imin - b_min, 0);
        press_key(1'b1);
        check("back_to_run", 32'(run_en), 1);
        check("field_none", 32'(set_field), 0);

        // Bouncing increase: 3 high, 1 low, then stable high.
        press_key(1'b1);
        b_min = c_imin;
        @(negedge clk);
        increase_key = 1'b1;
        repeat (3) @(negedge clk);
        increase_key = 1'b0;
        @(negedge clk);
        increase_key = 1'b1;
        repeat (10) @(negedge clk);
        increase_key = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_one_inc", c_imin - b_min, 1);
        b_min = c_imin;
        increase_key = 1'b1;
        repeat (3) @(negedge clk);
        increase_key = 1'b0;
        repeat (10) @(negedge clk);
        check("short_bounce_none", c_imin - b_min, 0);
        check("still_set_min", 32'(set_field), 1);

        // Timeout back to RUN, then a timed fresh entry.
        for (int i = 0; i < 60 && run_en !== 1'b1; i++) @(negedge clk);
        check("timeout_to_run", 32'(run_en), 1);
        @(negedge clk);
        set_key = 1'b1;
        for (int i = 0; i < 20 && set_mode !== 1'b1; i++) @(negedge clk);
        check("reenter_set", 32'(set_mode), 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 2) set_key = 1'b0;
            if (i == 4) check("blink_solid", 32'(blink_mask), 0);
            if (i == 5) check("blink_blank", 32'(blink_mask), 32'(M_MIN));
            if (i == 10) check("blink_back", 32'(blink_mask), 0);
            if (i == 39) check("timeout_not_yet", 32'(run_en), 0);
            if (i == 40) check("timeout_at_40", 32'(run_en), 1);
        end

        // Power drop in SET_HOUR.
        press_key(1'b1);
        press_key(1'b1);
        check("in_set_hour", 32'(set_field), 2);
        @(negedge clk);
        power_state = 1'b0;
        @(negedge clk);
        check("off_run_en", 32'(run_en), 0);
        check("off_set_mode", 32'(set_mode), 0);
        check("off_field", 32'(set_field), 0);
        check("off_mask", 32'(blink_mask), 0);
        repeat (3) @(negedge clk);
        power_state = 1'b1;
        @(negedge clk);
        check("power_back_run", 32'(run_en), 1);

        // Async reset mid-debounce.
        @(negedge clk);
        set_key = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_run_en", 32'(run_en), 0);
        check("async_rst_mode", 32'(set_mode), 0);
        @(negedge clk);
        set_key = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw_mode = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (set_mode === 1'b1) saw_mode = 1'b1;
        end
        check("no_press_after_rst", 32'(saw_mode), 0);
        check("run_after_rst2", 32'(run_en), 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_set_controller.md
Name: timer_set_controller

Overview:
- Sequencing controller for the hh:mm:ss timer datapath.
- Debounces the raw set and increase buttons and runs the run/set mode FSM.
- Produces single-cycle increment and clear commands plus the 1 Hz count tick for the time counters.
- Drives a per-digit blink mask to the seven-segment display stage so the field being edited flashes.

Parameters:
- TICK_DIV, 100000000: clock cycles per second tick (1 Hz from 100 MHz).
- DEBOUNCE_CYC, 20: consecutive stable cycles needed to accept a key level change.
- TIMEOUT_CYC, 1000000000: idle cycles in a set state before automatic return to RUN (10 s).
- BLINK_DIV, 50000000: cycles per blink half-period.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- power_state  in  1  1 = system powered on
- set_key  in  1  raw, asynchronous button; each press steps the edit field
- increase_key  in  1  raw, asynchronous button; each press increments the edited field
- run_en  out  1  counters may advance on sec_tick
- sec_tick  out  1  one-cycle pulse, once per TICK_DIV cycles while in RUN
- set_mode  out  1  1 in SET_MIN or SET_HOUR
- set_field  out  2  00 none, 01 minute, 10 hour
- inc_min  out  1  one-cycle minute increment command (counter wraps 59->0 itself)
- inc_hour  out  1  one-cycle hour increment command (counter wraps 23->0 itself)
- clr_sec  out  1  one-cycle seconds clear command
- blink_mask  out  6  1 = blank digit; bit5..0 = hour tens, hour units, minute tens, minute units, second tens, second units

Behaviour:
- Reset: asynchronous, active-low.
  - FSM goes to OFF.
  - All counters and synchronisers go to 0.
  - Every output is 0, including set_field=00 and blink_mask=000000.
  - Reset asserted mid-edit abandons the edit; no command pulses are emitted.
- Key path, per key:
  - Two-flop synchroniser.
  - Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
  - A press event is a one-cycle pulse on the cycle the debounced level goes 0->1. Release produces nothing.
  - Latency from a clean raw edge to the press pulse is 2+DEBOUNCE_CYC cycles.
- FSM states: OFF, RUN, SET_MIN, SET_HOUR.
  - All outputs are registered. A transition or command triggered by an event in cycle N is visible in cycle N+1.
  - Any state, power_state=0 -> OFF. Key events are ignored while in OFF.
  - OFF, power_state=1 -> RUN.
  - RUN, set press -> SET_MIN, with clr_sec pulsed for one cycle.
  - SET_MIN, set press -> SET_HOUR.
  - SET_HOUR, set press -> RUN.
  - SET_MIN, increase press -> inc_min pulse. SET_HOUR, increase press -> inc_hour pulse.
  - In RUN, increase presses are ignored.
  - If set and increase presses occur in the same cycle, set wins and the increase is discarded.
- Timeout:
  - The idle counter clears on entry to a set state and on every accepted press.
  - When it reaches TIMEOUT_CYC-1 the FSM goes to RUN. No commands are issued.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; sec_tick is asserted at the terminal count, then the counter wraps to 0.
  - Holds at 0 outside RUN, so the first tick after re-entering RUN arrives exactly TICK_DIV cycles later.
  - run_en = (state==RUN).
- Blink:
  - The phase counter toggles a blank phase every BLINK_DIV cycles.
  - Phase is forced visible and the counter cleared on entry to a set state and on every increase press, so the digits are solid for a full half-period after an edit.
  - During the blank phase: SET_MIN -> 001100, SET_HOUR -> 110000. Otherwise the mask is 000000.
- Width rules:
  - Counters are sized by $clog2 of their parameter.
  - Comparisons use full width with no truncation.
  - Parameter values of 1 are legal; the tick then fires every cycle in RUN.

Decomposition:
- Package timer_ctrl_pkg holds:
  - state encoding (OFF=2'd0, RUN=2'd1, SET_MIN=2'd2, SET_HOUR=2'd3);
  - set_field codes;
  - blink mask constants MASK_MIN=6'b001100 and MASK_HOUR=6'b110000.
- One sub-module: key_debounce (synchroniser, stable counter, rising-edge pulse), instantiated for set_key and increase_key.

Test Plan (bench parameters TICK_DIV=10, DEBOUNCE_CYC=4, TIMEOUT_CYC=40, BLINK_DIV=5):
- Reset release with power_state=1 -> RUN at the next clock; sec_tick high on exactly every 10th cycle; all commands 0.
- Clean set press in RUN -> the press pulse occurs 6 cycles after the raw edge; next cycle shows state SET_MIN, set_field=01, clr_sec high for 1 cycle; sec_tick stops.
- Increase pressed 3 times in SET_MIN -> exactly 3 single-cycle inc_min pulses and no inc_hour; set press -> set_field=10; 2 increase presses -> 2 inc_hour pulses; set press -> RUN.
- Raw increase bouncing 1-0-1 with a 3-cycle high and then stable high -> exactly one inc_min; bounce shorter than 4 cycles -> no pulse.
- SET_MIN with no presses -> returns to RUN after 40 idle cycles; blink_mask alternates 001100/000000 every 5 cycles before then, and is solid 000000 for 5 cycles after each increase press.
- power_state dropped in SET_HOUR -> OFF next cycle with all outputs 0; async reset asserted mid-debounce -> outputs 0 immediately and no pulse after release.
